// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: shared definitions for the region-growing processing-element controller.
//   - pe_state_e   : evaluation-loop state encodings (STOP/COST/ROOT/SAVE)
//   - NB_*         : neighbour index constants, order N,E,S,W,NE,SE,SW,NW
//   - NBH_*        : neighborhood selection codes and the matching neighbour masks
package pe_ctrl_pkg;

    typedef enum logic [1:0] {
        STOP_ST = 2'b00,
        COST_ST = 2'b01,
        ROOT_ST = 2'b10,
        SAVE_ST = 2'b11
    } pe_state_e;

    localparam int unsigned NB_COUNT = 8;

    localparam logic [2:0] NB_N  = 3'd0;
    localparam logic [2:0] NB_E  = 3'd1;
    localparam logic [2:0] NB_S  = 3'd2;
    localparam logic [2:0] NB_W  = 3'd3;
    localparam logic [2:0] NB_NE = 3'd4;
    localparam logic [2:0] NB_SE = 3'd5;
    localparam logic [2:0] NB_SW = 3'd6;
    localparam logic [2:0] NB_NW = 3'd7;

    localparam logic NBH_4CONN = 1'b0;
    localparam logic NBH_8CONN = 1'b1;

    localparam logic [7:0] NB_MASK_4CONN = 8'h0F;
    localparam logic [7:0] NB_MASK_8CONN = 8'hFF;

endpackage

// File: rtl/pe_edge_cost.sv
// pe_edge_cost: combinational candidate cost for one neighbour.
//   cost = sat_ACC_W(nb_acc + edge), edge = |pix_a - pix_b|
// Optional macro PE_CTRL_DIAG_WEIGHT_EN: adds parameter DIAG; when DIAG=1 the edge term
// becomes e + (e >> 1) for diagonal neighbours.
// Ports:
//   pix_a   own pixel intensity
//   pix_b   neighbour pixel intensity
//   nb_acc  neighbour accumulated cost
//   cost    saturated candidate cost
module pe_edge_cost #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned ACC_W = 12
`ifdef PE_CTRL_DIAG_WEIGHT_EN
    ,
    parameter bit DIAG = 1'b0
`endif
) (
    input  logic [PIX_W-1:0] pix_a,
    input  logic [PIX_W-1:0] pix_b,
    input  logic [ACC_W-1:0] nb_acc,
    output logic [ACC_W-1:0] cost
);

    // Wide enough for the larger operand plus a carry bit.
    localparam int unsigned SUM_W = ((ACC_W > PIX_W + 1) ? ACC_W : PIX_W + 1) + 1;

    logic [PIX_W-1:0] edge_abs;
    logic [PIX_W:0]   edge_term;
    logic [SUM_W-1:0] sum;

    assign edge_abs = (pix_a >= pix_b) ? (pix_a - pix_b) : (pix_b - pix_a);

`ifdef PE_CTRL_DIAG_WEIGHT_EN
    assign edge_term = DIAG ? ({1'b0, edge_abs} + {2'b00, edge_abs[PIX_W-1:1]})
                            : {1'b0, edge_abs};
`else
    assign edge_term = {1'b0, edge_abs};
`endif

    assign sum  = SUM_W'(nb_acc) + SUM_W'(edge_term);
    assign cost = (sum > SUM_W'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

endmodule

// File: rtl/pe_ctrl.sv
// pe_ctrl: per-pixel controller for shortest-path region growing.
// Loop STOP -> COST -> ROOT -> SAVE -> STOP; a conquest pulse marks the STOP cycle after a
// SAVE that improved the pixel's accumulated cost.
// Optional macro PE_CTRL_DIAG_WEIGHT_EN: diagonal neighbours (4..7) use a 1.5x edge weight.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   run            1 = active, 0 = synchronous clear
//   neighborhood   0 = 4-connected, 1 = 8-connected
//   seed           pixel is a region root (cost 0)
//   pixel          own intensity
//   nb_valid       per-neighbour transmit flags (N,E,S,W,NE,SE,SW,NW)
//   nb_pixel       packed neighbour intensities
//   nb_acc         packed neighbour accumulated costs
//   state          loop state (STOP=00, COST=01, ROOT=10, SAVE=11)
//   conquest       one-cycle improvement pulse
//   acc_cost       current best accumulated cost
//   root_dir       neighbour index that supplied acc_cost
//   conquered      sticky valid flag for acc_cost
module pe_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned ACC_W = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    input  logic                      neighborhood,
    input  logic                      seed,
    input  logic [PIX_W-1:0]          pixel,
    input  logic [7:0]                nb_valid,
    input  logic [NB_COUNT*PIX_W-1:0] nb_pixel,
    input  logic [NB_COUNT*ACC_W-1:0] nb_acc,
    output logic [1:0]                state,
    output logic                      conquest,
    output logic [ACC_W-1:0]          acc_cost,
    output logic [2:0]                root_dir,
    output logic                      conquered
);

    pe_state_e        state_q, state_d;
    logic [ACC_W-1:0] cand_q, cand_d;
    logic [2:0]       idx_q, idx_d;
    logic             upd_q, upd_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [2:0]       dir_q, dir_d;
    logic             conq_q, conq_d;
    logic             conquest_q, conquest_d;

    logic [7:0]       active;
    logic [ACC_W-1:0] nb_cost [NB_COUNT];
    logic [ACC_W-1:0] min_cost;
    logic [2:0]       min_idx;
    logic             found;

    assign active = nb_valid & ((neighborhood == NBH_8CONN) ? NB_MASK_8CONN : NB_MASK_4CONN);

    for (genvar g = 0; g < NB_COUNT; g++) begin : g_edge
        pe_edge_cost #(
            .PIX_W (PIX_W),
            .ACC_W (ACC_W)
`ifdef PE_CTRL_DIAG_WEIGHT_EN
            ,
            .DIAG  (g >= int'(NB_NE))
`endif
        ) u_edge_cost (
            .pix_a  (pixel),
            .pix_b  (nb_pixel[g*PIX_W +: PIX_W]),
            .nb_acc (nb_acc[g*ACC_W +: ACC_W]),
            .cost   (nb_cost[g])
        );
    end

    // Minimum over active neighbours; strict compare keeps the lowest index on ties.
    always_comb begin
        min_cost = {ACC_W{1'b1}};
        min_idx  = NB_N;
        found    = 1'b0;
        for (int i = 0; i < NB_COUNT; i++) begin
            if (active[i] && (!found || (nb_cost[i] < min_cost))) begin
                min_cost = nb_cost[i];
                min_idx  = 3'(i);
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        idx_d      = idx_q;
        upd_d      = upd_q;
        acc_d      = acc_q;
        dir_d      = dir_q;
        conq_d     = conq_q;
        conquest_d = 1'b0;
        if (!run) begin
            state_d = STOP_ST;
            cand_d  = '0;
            idx_d   = '0;
            upd_d   = 1'b0;
            acc_d   = {ACC_W{1'b1}};
            dir_d   = '0;
            conq_d  = 1'b0;
        end else begin
            unique case (state_q)
                STOP_ST: begin
                    if (seed || (active != 8'h00)) begin
                        state_d = COST_ST;
                    end
                end
                COST_ST: begin
                    cand_d  = seed ? '0 : min_cost;
                    idx_d   = seed ? NB_N : min_idx;
                    state_d = ROOT_ST;
                end
                ROOT_ST: begin
                    upd_d   = !conq_q || (cand_q < acc_q);
                    state_d = SAVE_ST;
                end
                SAVE_ST: begin
                    if (upd_q) begin
                        acc_d      = cand_q;
                        dir_d      = idx_q;
                        conq_d     = 1'b1;
                        conquest_d = 1'b1;
                    end
                    state_d = STOP_ST;
                end
                default: state_d = STOP_ST;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= STOP_ST;
            cand_q     <= '0;
            idx_q      <= '0;
            upd_q      <= 1'b0;
            acc_q      <= {ACC_W{1'b1}};
            dir_q      <= '0;
            conq_q     <= 1'b0;
            conquest_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            idx_q      <= idx_d;
            upd_q      <= upd_d;
            acc_q      <= acc_d;
            dir_q      <= dir_d;
            conq_q     <= conq_d;
            conquest_q <= conquest_d;
        end
    end

    assign state     = state_q;
    assign conquest  = conquest_q;
    assign acc_cost  = acc_q;
    assign root_dir  = dir_q;
    assign conquered = conq_q;

endmodule

// File: tb/tb_pe_ctrl.sv
// tb_pe_ctrl: directed bench for pe_ctrl with a behavioural reference model.
// The model tracks the evaluation step (0..3 after a trigger) and computes the best
// neighbour cost with plain integer arithmetic when the COST step is taken.
module tb_pe_ctrl;

    localparam int PIX_W = 8;
    localparam int ACC_W = 12;
    localparam int MAXC  = (1 << ACC_W) - 1;

    logic                 clk;
    logic                 rst_n;
    logic                 run;
    logic                 neighborhood;
    logic                 seed;
    logic [PIX_W-1:0]     pixel;
    logic [7:0]           nb_valid;
    logic [8*PIX_W-1:0]   nb_pixel;
    logic [8*ACC_W-1:0]   nb_acc;
    logic [1:0]           state;
    logic                 conquest;
    logic [ACC_W-1:0]     acc_cost;
    logic [2:0]           root_dir;
    logic                 conquered;

    int n_total = 0;
    int n_bad   = 0;

    pe_ctrl #(
        .PIX_W (PIX_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .neighborhood (neighborhood),
        .seed         (seed),
        .pixel        (pixel),
        .nb_valid     (nb_valid),
        .nb_pixel     (nb_pixel),
        .nb_acc       (nb_acc),
        .state        (state),
        .conquest     (conquest),
        .acc_cost     (acc_cost),
        .root_dir     (root_dir),
        .conquered    (conquered)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_step;     // cycles into the current evaluation, 0 = idle/STOP
    int m_acc;
    int m_dir;
    int m_conq;
    int m_pulse;
    int m_pend_c;
    int m_pend_d;
    int m_pend_u;

    function automatic bit is_active(int i);
        return nb_valid[i] && (neighborhood || (i < 4));
    endfunction

    function automatic int cand_of(int i);
        int p, q, e, c;
        p = int'(pixel);
        q = int'(nb_pixel[i*PIX_W +: PIX_W]);
        e = (p > q) ? p - q : q - p;
`ifdef PE_CTRL_DIAG_WEIGHT_EN
        if (i >= 4) e = e + e / 2;
`endif
        c = int'(nb_acc[i*ACC_W +: ACC_W]) + e;
        return (c > MAXC) ? MAXC : c;
    endfunction

    function automatic int best_cost();
        int b;
        b = -1;
        if (seed) return 0;
        for (int i = 0; i < 8; i++)
            if (is_active(i) && (b < 0 || cand_of(i) < b)) b = cand_of(i);
        return (b < 0) ? MAXC : b;
    endfunction

    function automatic int best_dir();
        int b, d;
        b = -1;
        d = 0;
        if (seed) return 0;
        for (int i = 0; i < 8; i++)
            if (is_active(i) && (b < 0 || cand_of(i) < b)) begin
                b = cand_of(i);
                d = i;
            end
        return d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !run) begin
            m_step  <= 0;
            m_acc   <= MAXC;
            m_dir   <= 0;
            m_conq  <= 0;
            m_pulse <= 0;
            m_pend_u <= 0;
        end else begin
            m_pulse <= 0;
            case (m_step)
                0: if (seed || is_active(0) || is_active(1) || is_active(2) || is_active(3) ||
                       is_active(4) || is_active(5) || is_active(6) || is_active(7))
                       m_step <= 1;
                1: begin
                    m_pend_c <= best_cost();
                    m_pend_d <= best_dir();
                    m_pend_u <= int'(m_conq == 0 || best_cost() < m_acc);
                    m_step   <= 2;
                end
                2: m_step <= 3;
                default: begin
                    if (m_pend_u != 0) begin
                        m_acc   <= m_pend_c;
                        m_dir   <= m_pend_d;
                        m_conq  <= 1;
                        m_pulse <= 1;
                    end
                    m_step <= 0;
                end
            endcase
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; outputs are compared against the model 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        n_total++;
        if (state !== 2'(m_step) || conquest !== 1'(m_pulse) || acc_cost !== ACC_W'(m_acc) ||
            root_dir !== 3'(m_dir) || conquered !== 1'(m_conq)) begin
            n_bad++;
            $display("FAIL model t=%0t: got st=%0d cq=%0b acc=%0d dir=%0d cd=%0b expected st=%0d cq=%0d acc=%0d dir=%0d cd=%0d",
                     $time, state, conquest, acc_cost, root_dir, conquered,
                     m_step, m_pulse, m_acc, m_dir, m_conq);
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_nb(input int i, input int pix, input int acc);
        nb_pixel[i*PIX_W +: PIX_W] = PIX_W'(pix);
        nb_acc[i*ACC_W +: ACC_W]   = ACC_W'(acc);
    endtask

    task automatic do_clear();
        run      = 1'b0;
        nb_valid = 8'h00;
        nb_pixel = '0;
        nb_acc   = '0;
        step();
        run = 1'b1;
    endtask

    task automatic check_outs(input string tag, input int st, input int cq, input int acc,
                              input int dir, input int cd);
        check({tag, ".state"}, int'(state), st);
        check({tag, ".conquest"}, int'(conquest), cq);
        check({tag, ".acc_cost"}, int'(acc_cost), acc);
        check({tag, ".root_dir"}, int'(root_dir), dir);
        check({tag, ".conquered"}, int'(conquered), cd);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n        = 1'b0;
        run          = 1'b0;
        neighborhood = 1'b0;
        seed         = 1'b0;
        pixel        = '0;
        nb_valid     = 8'h00;
        nb_pixel     = '0;
        nb_acc       = '0;
        steps(2);
        check_outs("reset", 0, 0, MAXC, 0, 0);
        rst_n = 1'b1;
        step();

        // Seed: 01,10,11,00 with conquest on return; then re-evaluation never updates.
        run  = 1'b1;
        seed = 1'b1;
        step(); check("seed.s1", int'(state), 1);
        step(); check("seed.s2", int'(state), 2);
        step(); check("seed.s3", int'(state), 3);
        step(); check_outs("seed.done", 0, 1, 0, 0, 1);
        steps(4); check_outs("seed.reeval", 0, 0, 0, 0, 1);
        seed = 1'b0;
        step(); check("seed.idle", int'(state), 0);

        // Diagonal-only valids in 4-connected mode: no transition.
        nb_valid = 8'hF0;
        steps(2); check("mask4.idle", int'(state), 0);

        // 4-conn vs 8-conn.
        do_clear();
        check("clear.acc", int'(acc_cost), MAXC);
        pixel = 8'd100;
        set_nb(0, 90, 5);
        set_nb(4, 100, 0);
        nb_valid = 8'h11;
        steps(4); check_outs("conn4", 0, 1, 15, 0, 1);
        neighborhood = 1'b1;
        steps(4); check_outs("conn8", 0, 1, 0, 4, 1);
        nb_valid = 8'h00;
        neighborhood = 1'b0;
        step();

        // Tie: N and S both 7 -> N; later equal 7 from W does not update.
        do_clear();
        pixel = 8'd50;
        set_nb(0, 50, 7);
        set_nb(2, 53, 4);
        nb_valid = 8'h05;
        steps(4); check_outs("tie", 0, 1, 7, 0, 1);
        set_nb(3, 48, 5);
        nb_valid = 8'h08;
        steps(2);
        set_nb(3, 48, 0);  // changed after sampling: must be ignored
        steps(2); check_outs("tie.equal", 0, 0, 7, 0, 1);
        nb_valid = 8'h00;
        step();

        // Saturation: 4090 + 20 -> 4095, still accepted when unconquered.
        do_clear();
        pixel = 8'd20;
        set_nb(0, 0, 4090);
        nb_valid = 8'h01;
        steps(4); check_outs("sat", 0, 1, MAXC, 0, 1);
        nb_valid = 8'h00;
        step();

        // Abort in ROOT.
        do_clear();
        seed = 1'b1;
        steps(2); check("abort.root", int'(state), 2);
        run = 1'b0;
        step(); check_outs("abort", 0, 0, MAXC, 0, 0);
        seed = 1'b0;
        step(); check("abort.nopulse", int'(conquest), 0);
        run = 1'b1;

        // Asynchronous reset in SAVE.
        seed = 1'b1;
        steps(3); check("rst.save", int'(state), 3);
        rst_n = 1'b0;
        #1;
        check_outs("rst.async", 0, 0, MAXC, 0, 0);
        #2;
        rst_n = 1'b1;
        steps(4); check_outs("rst.restart", 0, 1, 0, 0, 1);
        seed = 1'b0;
        steps(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
